// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM between two requesters.
// RAM controls are registered; read data is routed back to the issuing requester.
module ram_port_arbiter #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  // Stage 0 sits beside the RAM issue registers; RD_LAT+1 more stages
  // cover the RAM sample edge plus its read latency.
  localparam int STAGES = RD_LAT + 1;

  typedef enum logic {LAST_A = 1'b0, LAST_B = 1'b1} last_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  last_e             last_q, last_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic              ram_we_q, ram_we_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic [STAGES:0]   vld_pipe_q, vld_pipe_d;
  logic [STAGES:0]   own_pipe_q, own_pipe_d;  // 1 = B owns the read
  logic              any_gnt;
  req_t              sel;

  always_comb begin
    a_gnt   = rst_n & a_req & (~b_req | (last_q == LAST_B));
    b_gnt   = rst_n & b_req & (~a_req | (last_q == LAST_A));
    any_gnt = a_gnt | b_gnt;
    sel     = b_gnt ? req_t'{b_we, b_addr, b_wdata} : req_t'{a_we, a_addr, a_wdata};

    last_d      = last_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_we_d    = 1'b0;
    if (any_gnt) begin
      last_d      = b_gnt ? LAST_B : LAST_A;
      ram_addr_d  = sel.addr;
      ram_wdata_d = sel.wdata;
      ram_we_d    = sel.we;
    end
    vld_pipe_d = {vld_pipe_q[STAGES-1:0], any_gnt & ~sel.we};
    own_pipe_d = {own_pipe_q[STAGES-1:0], b_gnt};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q      <= LAST_B;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_wdata_q <= '0;
      vld_pipe_q  <= '0;
      own_pipe_q  <= '0;
    end else begin
      last_q      <= last_d;
      ram_addr_q  <= ram_addr_d;
      ram_we_q    <= ram_we_d;
      ram_wdata_q <= ram_wdata_d;
      vld_pipe_q  <= vld_pipe_d;
      own_pipe_q  <= own_pipe_d;
    end
  end

  always_comb begin
    ram_addr  = ram_addr_q;
    ram_we    = ram_we_q;
    ram_wdata = ram_wdata_q;
    a_rvalid  = vld_pipe_q[STAGES] & ~own_pipe_q[STAGES];
    b_rvalid  = vld_pipe_q[STAGES] &  own_pipe_q[STAGES];
    a_rdata   = a_rvalid ? ram_rdata : '0;
    b_rdata   = b_rvalid ? ram_rdata : '0;
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench: cycle vectors against a behavioural RAM (RD_LAT=1), plus a
// hand-written reset-during-read sequence.
module tb_ram_port_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a_req, a_we, b_req, b_we;
  logic [5:0] a_addr, b_addr;
  logic [7:0] a_wdata, b_wdata;
  logic       a_gnt, b_gnt, a_rvalid, b_rvalid;
  logic [7:0] a_rdata, b_rdata;
  logic [5:0] ram_addr;
  logic       ram_we;
  logic [7:0] ram_wdata, ram_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram_port_arbiter #(.ADDR_W(6), .DATA_W(8), .RD_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  // RAM: samples address/write on the edge after issue, word appears one edge later.
  logic [7:0] mem [64];
  logic [7:0] rd_s;
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    rd_s      <= mem[ram_addr];
    ram_rdata <= rd_s;
  end

  typedef struct {
    logic ar, aw; logic [5:0] aa; logic [7:0] ad;
    logic br, bw; logic [5:0] ba; logic [7:0] bd;
    logic eag, ebg, ewe; logic [5:0] eaddr;
    logic earv; logic [7:0] eard;
    logic ebrv; logic [7:0] ebrd;
  } vec_t;

  vec_t vecs[$];

  // op codes: 0 idle, 1 read, 2 write
  function automatic vec_t v(int aop, int aa, int ad, int bop, int ba, int bd,
                             int eag, int ebg, int ewe, int eaddr,
                             int earv, int eard, int ebrv, int ebrd);
    vec_t r;
    r.ar = (aop != 0); r.aw = (aop == 2); r.aa = 6'(aa); r.ad = 8'(ad);
    r.br = (bop != 0); r.bw = (bop == 2); r.ba = 6'(ba); r.bd = 8'(bd);
    r.eag = (eag != 0); r.ebg = (ebg != 0); r.ewe = (ewe != 0); r.eaddr = 6'(eaddr);
    r.earv = (earv != 0); r.eard = 8'(eard); r.ebrv = (ebrv != 0); r.ebrd = 8'(ebrd);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic set_a(input logic r, input logic w, input logic [5:0] ad, input logic [7:0] d);
    a_req = r; a_we = w; a_addr = ad; a_wdata = d;
  endtask

  task automatic set_b(input logic r, input logic w, input logic [5:0] ad, input logic [7:0] d);
    b_req = r; b_we = w; b_addr = ad; b_wdata = d;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 8'(i) ^ 8'h5A;

    // write/read A; B stream of writes then reads; simultaneous reads;
    // address boundary; withdrawn B request followed by a real contest
    vecs.push_back(v(2,'h2F,'hAF, 0,0,0,     1,0,0,'h00, 0,0,    0,0));
    vecs.push_back(v(1,'h2F,0,    0,0,0,     1,0,1,'h2F, 0,0,    0,0));
    vecs.push_back(v(0,0,0,       0,0,0,     0,0,0,'h2F, 0,0,    0,0));
    vecs.push_back(v(0,0,0,       0,0,0,     0,0,0,'h2F, 0,0,    0,0));
    vecs.push_back(v(0,0,0,       0,0,0,     0,0,0,'h2F, 1,'hAF, 0,0));
    vecs.push_back(v(0,0,0,       0,0,0,     0,0,0,'h2F, 0,0,    0,0));
    vecs.push_back(v(0,0,0,       2,'h00,'h10, 0,1,0,'h2F, 0,0, 0,0));
    vecs.push_back(v(0,0,0,       2,'h01,'h11, 0,1,1,'h00, 0,0, 0,0));
    vecs.push_back(v(0,0,0,       2,'h02,'h12, 0,1,1,'h01, 0,0, 0,0));
    vecs.push_back(v(0,0,0,       2,'h03,'h13, 0,1,1,'h02, 0,0, 0,0));
    vecs.push_back(v(0,0,0,       1,'h00,0,  0,1,1,'h03, 0,0,    0,0));
    vecs.push_back(v(0,0,0,       1,'h01,0,  0,1,0,'h00, 0,0,    0,0));
    vecs.push_back(v(0,0,0,       1,'h02,0,  0,1,0,'h01, 0,0,    0,0));
    vecs.push_back(v(0,0,0,       1,'h03,0,  0,1,0,'h02, 0,0,    1,'h10));
    vecs.push_back(v(0,0,0,       0,0,0,     0,0,0,'h03, 0,0,    1,'h11));
    vecs.push_back(v(0,0,0,       0,0,0,     0,0,0,'h03, 0,0,    1,'h12));
    vecs.push_back(v(0,0,0,       0,0,0,     0,0,0,'h03, 0,0,    1,'h13));
    vecs.push_back(v(0,0,0,       0,0,0,     0,0,0,'h03, 0,0,    0,0));
    vecs.push_back(v(1,'h01,0,    1,'h02,0,  1,0,0,'h03, 0,0,    0,0));
    vecs.push_back(v(1,'h01,0,    1,'h02,0,  0,1,0,'h01, 0,0,    0,0));
    vecs.push_back(v(1,'h01,0,    1,'h02,0,  1,0,0,'h02, 0,0,    0,0));
    vecs.push_back(v(1,'h01,0,    1,'h02,0,  0,1,0,'h01, 1,'h11, 0,0));
    vecs.push_back(v(0,0,0,       0,0,0,     0,0,0,'h02, 0,0,    1,'h12));
    vecs.push_back(v(0,0,0,       0,0,0,     0,0,0,'h02, 1,'h11, 0,0));
    vecs.push_back(v(0,0,0,       0,0,0,     0,0,0,'h02, 0,0,    1,'h12));
    vecs.push_back(v(0,0,0,       0,0,0,     0,0,0,'h02, 0,0,    0,0));
    vecs.push_back(v(2,'h3F,'h55, 2,'h00,'hAA, 1,0,0,'h02, 0,0,  0,0));
    vecs.push_back(v(1,'h3F,0,    2,'h00,'hAA, 0,1,1,'h3F, 0,0,  0,0));
    vecs.push_back(v(1,'h3F,0,    1,'h00,0,  1,0,1,'h00, 0,0,    0,0));
    vecs.push_back(v(0,0,0,       1,'h00,0,  0,1,0,'h3F, 0,0,    0,0));
    vecs.push_back(v(0,0,0,       0,0,0,     0,0,0,'h00, 0,0,    0,0));
    vecs.push_back(v(0,0,0,       0,0,0,     0,0,0,'h00, 1,'h55, 0,0));
    vecs.push_back(v(0,0,0,       0,0,0,     0,0,0,'h00, 0,0,    1,'hAA));
    vecs.push_back(v(0,0,0,       0,0,0,     0,0,0,'h00, 0,0,    0,0));
    vecs.push_back(v(1,'h3F,0,    1,'h01,0,  1,0,0,'h00, 0,0,    0,0));
    vecs.push_back(v(1,'h3F,0,    0,0,0,     1,0,0,'h3F, 0,0,    0,0));
    vecs.push_back(v(0,0,0,       0,0,0,     0,0,0,'h3F, 0,0,    0,0));
    vecs.push_back(v(1,'h00,0,    1,'h01,0,  0,1,0,'h3F, 1,'h55, 0,0));
    vecs.push_back(v(1,'h00,0,    0,0,0,     1,0,0,'h01, 1,'h55, 0,0));
    vecs.push_back(v(0,0,0,       0,0,0,     0,0,0,'h00, 0,0,    0,0));
    vecs.push_back(v(0,0,0,       0,0,0,     0,0,0,'h00, 0,0,    1,'h11));
    vecs.push_back(v(0,0,0,       0,0,0,     0,0,0,'h00, 1,'hAA, 0,0));
    vecs.push_back(v(0,0,0,       0,0,0,     0,0,0,'h00, 0,0,    0,0));

    // reset state, with both requests raised to show grants are blocked
    rst_n = 1'b0;
    set_a(1, 0, 6'h01, 8'h00);
    set_b(1, 0, 6'h02, 8'h00);
    @(negedge clk); @(negedge clk);
    chk("reset a_gnt", a_gnt, 0);        chk("reset b_gnt", b_gnt, 0);
    chk("reset ram_we", ram_we, 0);      chk("reset ram_addr", ram_addr, 0);
    chk("reset ram_wdata", ram_wdata, 0);
    chk("reset a_rvalid", a_rvalid, 0);  chk("reset b_rvalid", b_rvalid, 0);
    chk("reset a_rdata", a_rdata, 0);    chk("reset b_rdata", b_rdata, 0);
    rst_n = 1'b1;
    set_a(0, 0, 0, 0);
    set_b(0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk); #1;
      set_a(vecs[i].ar, vecs[i].aw, vecs[i].aa, vecs[i].ad);
      set_b(vecs[i].br, vecs[i].bw, vecs[i].ba, vecs[i].bd);
      @(negedge clk);
      chk($sformatf("v%0d a_gnt", i), a_gnt, vecs[i].eag);
      chk($sformatf("v%0d b_gnt", i), b_gnt, vecs[i].ebg);
      chk($sformatf("v%0d ram_we", i), ram_we, vecs[i].ewe);
      chk($sformatf("v%0d ram_addr", i), ram_addr, vecs[i].eaddr);
      chk($sformatf("v%0d a_rvalid", i), a_rvalid, vecs[i].earv);
      chk($sformatf("v%0d a_rdata", i), a_rdata, vecs[i].eard);
      chk($sformatf("v%0d b_rvalid", i), b_rvalid, vecs[i].ebrv);
      chk($sformatf("v%0d b_rdata", i), b_rdata, vecs[i].ebrd);
    end

    // reset while a read is in flight and a write is registered but unsampled
    @(posedge clk); #1;
    set_a(1, 0, 6'h3F, 8'h00);
    @(negedge clk); chk("mid a_gnt read", a_gnt, 1);
    @(posedge clk); #1;
    set_a(1, 1, 6'h10, 8'hEE);
    @(negedge clk); chk("mid a_gnt write", a_gnt, 1);
    @(posedge clk); #1;
    a_req = 1'b0;
    chk("mid pending ram_we", ram_we, 1);
    chk("mid pending ram_addr", ram_addr, 6'h10);
    @(negedge clk);
    rst_n = 1'b0;
    set_a(1, 0, 6'h10, 8'h00);
    set_b(1, 0, 6'h00, 8'h00);
    #1;
    chk("mid rst ram_we", ram_we, 0);
    chk("mid rst ram_addr", ram_addr, 0);
    chk("mid rst a_gnt", a_gnt, 0);
    chk("mid rst b_gnt", b_gnt, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("mid rst%0d a_rvalid", k), a_rvalid, 0);
      chk($sformatf("mid rst%0d b_rvalid", k), b_rvalid, 0);
      chk($sformatf("mid rst%0d a_gnt", k), a_gnt, 0);
    end
    rst_n = 1'b1;
    #1;
    chk("post rst a_gnt", a_gnt, 1);
    chk("post rst b_gnt", b_gnt, 0);
    @(posedge clk); #1;
    a_req = 1'b0;
    @(negedge clk);
    chk("post rst b_gnt next", b_gnt, 1);
    chk("post rst ram_addr", ram_addr, 6'h10);
    chk("post rst ram_we", ram_we, 0);
    chk("post rst a_rvalid q1", a_rvalid, 0);
    chk("post rst b_rvalid q1", b_rvalid, 0);
    @(posedge clk); #1;
    b_req = 1'b0;
    @(negedge clk);
    chk("post rst a_rvalid q2", a_rvalid, 0);
    chk("post rst b_rvalid q2", b_rvalid, 0);
    @(negedge clk);
    chk("post rst a_rvalid q3", a_rvalid, 1);
    chk("cancelled write a_rdata", a_rdata, 8'h4A);
    @(negedge clk);
    chk("post rst a_rvalid q4", a_rvalid, 0);
    chk("post rst b_rvalid q4", b_rvalid, 1);
    chk("post rst b_rdata", b_rdata, 8'hAA);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
